instruction_fetch_unit: RTL

Fetch stage directly upstream of InstructionMemory. Owns the program counter and drives the 64-bit Address into instruction memory. Captures the returned 32-bit word into a one-entry instruction register (IR), tagged with its PC, for the decode stage. Resolves B/CBZ redirects from decode/ALU feedback, squashes the wrong-path fetch, supports stall, and halts when the PC runs past the end of the program.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encoding, instruction size, bubble word and default address limits.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam int          INSTR_BYTES        = 4;
  localparam logic [31:0] BUBBLE_WORD        = 32'h0;
  localparam logic [63:0] DEFAULT_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] DEFAULT_MEM_LIMIT  = 64'h0000_0000_0000_0064;

  // Branch offsets are in words; convert to a byte offset.
  function automatic logic [63:0] word_to_byte_offset(input logic [63:0] imm);
    return imm << 2;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic: sequential successor, branch target,
// and the redirect-aware selection between them.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter logic [63:0] START_ALIGN_MASK = DEFAULT_ALIGN_MASK
) (
  input  logic [63:0] pc,
  input  logic [63:0] instr_pc,
  input  logic [63:0] sign_ext_imm,
  input  logic        taken,
  output logic [63:0] pc_plus4,
  output logic [63:0] target,
  output logic [63:0] next_pc
);

  always_comb begin
    pc_plus4 = pc + 64'(INSTR_BYTES);
    // Target is relative to the branch instruction, not the current fetch PC.
    target   = (instr_pc + word_to_byte_offset(sign_ext_imm)) & START_ALIGN_MASK;
    next_pc  = taken ? target : pc_plus4;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures memory words into a one-entry IR,
// resolves B/CBZ redirects with a single bubble, and halts past the program end.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] START_ALIGN_MASK = DEFAULT_ALIGN_MASK,
  parameter logic [63:0] MEM_LIMIT        = DEFAULT_MEM_LIMIT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] StartPC,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        Zero,
  input  logic [63:0] SignExtImm64,
  input  logic [31:0] InstrData,
  output logic [63:0] Address,
  output logic [31:0] Instruction,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  output logic        Halted
);

  fetch_state_t state_reg, state_next;
  logic [63:0]  pc_reg, pc_next;
  logic [31:0]  ir_reg, ir_next;
  logic [63:0]  instr_pc_reg, instr_pc_next;
  logic         instr_valid_reg, instr_valid_next;

  logic         taken;
  logic [63:0]  pc_plus4;
  logic [63:0]  target;
  logic [63:0]  redirect_pc;

  // Only a real instruction in IR may redirect; bubbles and halt never do.
  assign taken = instr_valid_reg & (Uncondbranch | (Branch & Zero));

  next_pc_calc #(
    .START_ALIGN_MASK(START_ALIGN_MASK)
  ) u_next_pc (
    .pc           (pc_reg),
    .instr_pc     (instr_pc_reg),
    .sign_ext_imm (SignExtImm64),
    .taken        (taken),
    .pc_plus4     (pc_plus4),
    .target       (target),
    .next_pc      (redirect_pc)
  );

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    ir_next          = ir_reg;
    instr_pc_next    = instr_pc_reg;
    instr_valid_next = instr_valid_reg;

    case (state_reg)
      RUN: begin
        if (Stall) begin
          // Hold everything; a taken branch in IR resolves once stall drops.
        end else if (taken) begin
          pc_next          = redirect_pc;
          ir_next          = BUBBLE_WORD;
          instr_valid_next = 1'b0;
        end else if (pc_reg >= MEM_LIMIT) begin
          ir_next          = BUBBLE_WORD;
          instr_valid_next = 1'b0;
          state_next       = HALT;
        end else begin
          ir_next          = InstrData;
          instr_pc_next    = pc_reg;
          instr_valid_next = 1'b1;
          pc_next          = pc_plus4;
        end
      end
      HALT: begin
        instr_valid_next = 1'b0;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg       <= RUN;
      pc_reg          <= StartPC & START_ALIGN_MASK;
      ir_reg          <= BUBBLE_WORD;
      instr_pc_reg    <= 64'h0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      ir_reg          <= ir_next;
      instr_pc_reg    <= instr_pc_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  assign Address     = pc_reg;
  assign Instruction = ir_reg;
  assign InstrPC     = instr_pc_reg;
  assign InstrValid  = instr_valid_reg;
  assign Halted      = (state_reg == HALT);

endmodule
